// File: rtl/btree_pkg.sv
// Shared types and node-layout helpers for the B-tree search engine.
// Node word, MSB to LSB: leaf, count, keys[KEYS-1..0], data[KEYS-1..0], next[KEYS..0].
package btree_pkg;

    typedef enum logic [1:0] {
        ST_FOUND     = 2'd0,
        ST_MISSING   = 2'd1,
        ST_DEPTH_ERR = 2'd2
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_COMPARE,
        S_RESP
    } state_e;

    function automatic int count_bits(input int keys);
        return $clog2(keys + 1);
    endfunction

    function automatic int data_off(input int addr_bits, input int keys);
        return (keys + 1) * addr_bits;
    endfunction

    function automatic int key_off(input int data_bits, input int addr_bits, input int keys);
        return data_off(addr_bits, keys) + keys * data_bits;
    endfunction

    function automatic int count_off(input int key_bits, input int data_bits,
                                     input int addr_bits, input int keys);
        return key_off(data_bits, addr_bits, keys) + keys * key_bits;
    endfunction

    function automatic int leaf_off(input int key_bits, input int data_bits,
                                    input int addr_bits, input int keys);
        return count_off(key_bits, data_bits, addr_bits, keys) + count_bits(keys);
    endfunction

    function automatic int node_bits(input int key_bits, input int data_bits,
                                     input int addr_bits, input int keys);
        return leaf_off(key_bits, data_bits, addr_bits, keys) + 1;
    endfunction

endpackage

// File: rtl/btree_node_compare.sv
// Combinational decode of one B-tree node against a search key: per-slot
// eq/gt, lowest matching data, child index and child link.
module btree_node_compare
    import btree_pkg::*;
#(
    parameter int KEY_BITS  = 8,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8,
    parameter int KEYS      = 3,
    localparam int NB   = node_bits(KEY_BITS, DATA_BITS, ADDR_BITS, KEYS),
    localparam int CW   = count_bits(KEYS),
    localparam int DOFF = data_off(ADDR_BITS, KEYS),
    localparam int KOFF = key_off(DATA_BITS, ADDR_BITS, KEYS),
    localparam int COFF = count_off(KEY_BITS, DATA_BITS, ADDR_BITS, KEYS),
    localparam int LOFF = leaf_off(KEY_BITS, DATA_BITS, ADDR_BITS, KEYS)
) (
    input  logic [NB-1:0]        node_i,
    input  logic [KEY_BITS-1:0]  key_i,
    output logic [KEYS-1:0]      eq_o,
    output logic [KEYS-1:0]      gt_o,
    output logic [CW-1:0]        child_o,
    output logic [ADDR_BITS-1:0] childAddr_o,
    output logic                 hit_o,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 leaf_o,
    output logic [CW-1:0]        count_o
);

    logic [CW-1:0]       countRaw;
    logic [KEY_BITS-1:0] slotKey;

    assign leaf_o   = node_i[LOFF];
    assign countRaw = node_i[COFF +: CW];
    assign count_o  = (countRaw > CW'(KEYS)) ? CW'(KEYS) : countRaw;

    // Walk slots high to low so the lowest matching slot supplies the data.
    always_comb begin
        eq_o        = '0;
        gt_o        = '0;
        child_o     = '0;
        hit_o       = 1'b0;
        data_o      = '0;
        slotKey     = '0;
        childAddr_o = '0;
        for (int i = KEYS - 1; i >= 0; i--) begin
            if (CW'(i) < count_o) begin
                slotKey = node_i[KOFF + i*KEY_BITS +: KEY_BITS];
                if (key_i == slotKey) begin
                    eq_o[i] = 1'b1;
                    hit_o   = 1'b1;
                    data_o  = node_i[DOFF + i*DATA_BITS +: DATA_BITS];
                end
                if (key_i > slotKey) begin
                    gt_o[i] = 1'b1;
                    child_o = child_o + CW'(1);
                end
            end
        end
        for (int j = 0; j <= KEYS; j++) begin
            if (child_o == CW'(j))
                childAddr_o = node_i[j*ADDR_BITS +: ADDR_BITS];
        end
    end

endmodule

// File: rtl/btree_search.sv
// Sequential B-tree lookup engine with internal node RAM and write port.
// Optional BTREE_SEARCH_STEPS_EN adds rsp_steps (nodes read for the result).
module btree_search
    import btree_pkg::*;
#(
    parameter int KEY_BITS  = 8,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 8,
    parameter int KEYS      = 3,
    parameter int MAX_DEPTH = 8,
    localparam int NODE_BITS = node_bits(KEY_BITS, DATA_BITS, ADDR_BITS, KEYS),
    localparam int CW        = count_bits(KEYS),
    localparam int SW        = $clog2(MAX_DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [NODE_BITS-1:0] wr_node,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [KEY_BITS-1:0]  req_key,
    input  logic [ADDR_BITS-1:0] req_root,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_status,
    output logic [DATA_BITS-1:0] rsp_data,
    output logic [ADDR_BITS-1:0] rsp_node
`ifdef BTREE_SEARCH_STEPS_EN
    ,
    output logic [SW-1:0]        rsp_steps
`endif
);

    logic [NODE_BITS-1:0] mem [2**ADDR_BITS];
    logic [NODE_BITS-1:0] node_q;

    state_e               state_q;
    logic [KEY_BITS-1:0]  key_q;
    logic [ADDR_BITS-1:0] cur_q;
    logic [SW-1:0]        depth_q;
    logic                 reqReady_q;
    logic                 rspValid_q;
    status_e              rspStatus_q;
    logic [DATA_BITS-1:0] rspData_q;
    logic [ADDR_BITS-1:0] rspNode_q;

    logic [KEYS-1:0]      eqVec;
    logic [KEYS-1:0]      gtVec;
    logic [CW-1:0]        childIdx;
    logic [CW-1:0]        nodeCount;
    logic [ADDR_BITS-1:0] childAddr;
    logic                 hit;
    logic                 leaf;
    logic [DATA_BITS-1:0] hitData;
    logic                 cmp_unused;

    logic                 done_d;
    status_e              status_d;
    logic [DATA_BITS-1:0] data_d;

    // RAM is never reset; nonblocking write gives read-first on address collision.
    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_addr] <= wr_node;
        node_q <= mem[cur_q];
    end

    btree_node_compare #(
        .KEY_BITS  (KEY_BITS),
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS),
        .KEYS      (KEYS)
    ) u_compare (
        .node_i      (node_q),
        .key_i       (key_q),
        .eq_o        (eqVec),
        .gt_o        (gtVec),
        .child_o     (childIdx),
        .childAddr_o (childAddr),
        .hit_o       (hit),
        .data_o      (hitData),
        .leaf_o      (leaf),
        .count_o     (nodeCount)
    );

    assign cmp_unused = ^{eqVec, gtVec, childIdx, nodeCount};

    always_comb begin
        done_d   = 1'b1;
        status_d = ST_MISSING;
        data_d   = '0;
        if (hit) begin
            status_d = ST_FOUND;
            data_d   = hitData;
        end else if (leaf || childAddr == '0) begin
            status_d = ST_MISSING;
        end else if (depth_q == SW'(MAX_DEPTH - 1)) begin
            status_d = ST_DEPTH_ERR;
        end else begin
            done_d = 1'b0;
        end
    end

`ifdef BTREE_SEARCH_STEPS_EN
    logic [SW-1:0] steps_q;
    assign rsp_steps = steps_q;
`endif

    // A null root is detected in READ so it still costs one cycle after acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            cur_q       <= '0;
            depth_q     <= '0;
            reqReady_q  <= 1'b1;
            rspValid_q  <= 1'b0;
            rspStatus_q <= ST_FOUND;
            rspData_q   <= '0;
            rspNode_q   <= '0;
`ifdef BTREE_SEARCH_STEPS_EN
            steps_q     <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        key_q      <= req_key;
                        cur_q      <= req_root;
                        depth_q    <= '0;
                        reqReady_q <= 1'b0;
                        state_q    <= S_READ;
                    end
                end
                S_READ: begin
                    if (cur_q == '0) begin
                        rspStatus_q <= ST_MISSING;
                        rspData_q   <= '0;
                        rspNode_q   <= '0;
                        rspValid_q  <= 1'b1;
`ifdef BTREE_SEARCH_STEPS_EN
                        steps_q     <= '0;
`endif
                        state_q     <= S_RESP;
                    end else begin
                        state_q <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (done_d) begin
                        rspStatus_q <= status_d;
                        rspData_q   <= data_d;
                        rspNode_q   <= cur_q;
                        rspValid_q  <= 1'b1;
`ifdef BTREE_SEARCH_STEPS_EN
                        steps_q     <= depth_q + SW'(1);
`endif
                        state_q     <= S_RESP;
                    end else begin
                        cur_q   <= childAddr;
                        depth_q <= depth_q + SW'(1);
                        state_q <= S_READ;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rspValid_q <= 1'b0;
                        reqReady_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = reqReady_q;
    assign rsp_valid  = rspValid_q;
    assign rsp_status = rspStatus_q;
    assign rsp_data   = rspData_q;
    assign rsp_node   = rspNode_q;

endmodule

// File: tb/tb_btree_search.sv
// Randomised self-checking bench for btree_search against a tree-walk model.
// Honours BTREE_SEARCH_STEPS_EN when the design is built with it.
module tb_btree_search;
    import btree_pkg::*;

    localparam int KB   = 8;
    localparam int DB   = 8;
    localparam int AB   = 8;
    localparam int NK   = 3;
    localparam int MAXD = 4;
    localparam int NB   = node_bits(KB, DB, AB, NK);

    logic          clock;
    logic          reset_n;
    logic          wr_en;
    logic [AB-1:0] wr_addr;
    logic [NB-1:0] wr_node;
    logic          req_valid;
    logic          req_ready;
    logic [KB-1:0] req_key;
    logic [AB-1:0] req_root;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [DB-1:0] rsp_data;
    logic [AB-1:0] rsp_node;
`ifdef BTREE_SEARCH_STEPS_EN
    logic [2:0]    rsp_steps;
`endif

    btree_search #(
        .KEY_BITS (KB), .DATA_BITS (DB), .ADDR_BITS (AB), .KEYS (NK), .MAX_DEPTH (MAXD)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_node    (wr_node),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_key    (req_key),
        .req_root   (req_root),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_data   (rsp_data),
        .rsp_node   (rsp_node)
`ifdef BTREE_SEARCH_STEPS_EN
        ,
        .rsp_steps  (rsp_steps)
`endif
    );

    // Reference tree image kept as plain arrays.
    logic          mLeaf  [256];
    int            mCount [256];
    logic [KB-1:0] mKeys  [256][NK];
    logic [DB-1:0] mData  [256][NK];
    logic [AB-1:0] mNext  [256][NK+1];

    int checkCount = 0;
    int passCount  = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    function automatic logic [NB-1:0] packNode(input int a);
        logic [1:0] cnt;
        cnt = 2'(mCount[a]);
        return {mLeaf[a], cnt,
                mKeys[a][2], mKeys[a][1], mKeys[a][0],
                mData[a][2], mData[a][1], mData[a][0],
                mNext[a][3], mNext[a][2], mNext[a][1], mNext[a][0]};
    endfunction

    task automatic writeNode(input int a, input logic leaf, input int cnt,
                             input int k0, input int k1, input int k2,
                             input int d0, input int d1, input int d2,
                             input int n0, input int n1, input int n2, input int n3);
        mLeaf[a] = leaf;  mCount[a] = cnt;
        mKeys[a][0] = 8'(k0); mKeys[a][1] = 8'(k1); mKeys[a][2] = 8'(k2);
        mData[a][0] = 8'(d0); mData[a][1] = 8'(d1); mData[a][2] = 8'(d2);
        mNext[a][0] = 8'(n0); mNext[a][1] = 8'(n1); mNext[a][2] = 8'(n2); mNext[a][3] = 8'(n3);
        @(negedge clock);
        wr_en   = 1'b1;
        wr_addr = 8'(a);
        wr_node = packNode(a);
        @(posedge clock);
        #1 wr_en = 1'b0;
    endtask

    // Walks the tree one node per level; latency is two edges per visited node.
    function automatic void modelSearch(input logic [KB-1:0] key, input logic [AB-1:0] root,
                                        output logic [1:0] st, output logic [DB-1:0] dat,
                                        output logic [AB-1:0] nd, output int steps, output int lat);
        logic [AB-1:0] cur;
        int n, c, hitIdx;
        st = 2'd1; dat = '0; nd = '0; steps = 0; lat = 1;
        cur = root;
        if (root == '0) return;
        for (int d = 1; d <= MAXD; d++) begin
            nd = cur; steps = d; lat = 2 * d;
            n = (mCount[cur] > NK) ? NK : mCount[cur];
            hitIdx = -1; c = 0;
            for (int i = 0; i < n; i++) begin
                if (hitIdx < 0 && key == mKeys[cur][i]) hitIdx = i;
                if (key > mKeys[cur][i]) c++;
            end
            if (hitIdx >= 0) begin
                st = 2'd0; dat = mData[cur][hitIdx];
                return;
            end
            if (mLeaf[cur] || mNext[cur][c] == '0) return;
            if (d == MAXD) begin
                st = 2'd2;
                return;
            end
            cur = mNext[cur][c];
        end
    endfunction

    // One full request/response; 'hold' cycles of backpressure with a competing request.
    task automatic applyStimulus(input logic [KB-1:0] key, input logic [AB-1:0] root, input int hold);
        logic [1:0] st; logic [DB-1:0] dat; logic [AB-1:0] nd;
        int steps, lat, edges;
        modelSearch(key, root, st, dat, nd, steps, lat);
        checkOutput("ready", {31'd0, req_ready}, 32'd1);
        @(negedge clock);
        req_valid = 1'b1; req_key = key; req_root = root;
        @(posedge clock);
        #1 req_valid = 1'b0;
        edges = 0;
        while (!rsp_valid && edges < 40) begin
            @(posedge clock);
            #1 edges++;
        end
        checkOutput("latency", edges, lat);
        checkOutput("status", {30'd0, rsp_status}, {30'd0, st});
        checkOutput("data", {24'd0, rsp_data}, {24'd0, dat});
        checkOutput("node", {24'd0, rsp_node}, {24'd0, nd});
`ifdef BTREE_SEARCH_STEPS_EN
        checkOutput("steps", {29'd0, rsp_steps}, 32'(steps));
`endif
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_key = key + 8'd1; req_root = 8'd1;
            @(posedge clock);
            #1 checkOutput("hold", {12'd0, rsp_valid, req_ready, rsp_status, rsp_data, rsp_node},
                           {12'd0, 1'b1, 1'b0, st, dat, nd});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1 rsp_ready = 1'b0;
        checkOutput("handshake", {30'd0, rsp_valid, req_ready}, 32'd1);
    endtask

    initial begin
        logic [KB-1:0] rk;
        logic [AB-1:0] rr;
        int a, k0, k1, k2;
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_node = '0;
        req_valid = 1'b0; req_key = '0; req_root = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        #1 checkOutput("reset", {12'd0, rsp_valid, req_ready, rsp_status, rsp_data, rsp_node}, 32'h0004_0000);
`ifdef BTREE_SEARCH_STEPS_EN
        checkOutput("reset_steps", {29'd0, rsp_steps}, 32'd0);
`endif

        writeNode(1, 1'b0, 3, 10, 20, 30, 'hA1, 'hA2, 'hA3, 2, 3, 4, 5);
        writeNode(2, 1'b1, 2, 3, 7, 0, 'hB1, 'hB2, 0, 0, 0, 0, 0);
        writeNode(3, 1'b1, 2, 12, 15, 0, 'hC1, 'hC2, 0, 0, 0, 0, 0);
        writeNode(4, 1'b1, 1, 25, 0, 0, 'hD1, 0, 0, 0, 0, 0, 0);
        writeNode(5, 1'b1, 3, 40, 50, 60, 'hE1, 'hE2, 'hE3, 0, 0, 0, 0);
        writeNode(6, 1'b0, 1, 50, 60, 70, 'h61, 'h62, 'h63, 0, 7, 0, 0);
        writeNode(7, 1'b1, 1, 99, 0, 0, 'h71, 0, 0, 0, 0, 0, 0);

        applyStimulus(8'd20, 8'd1, 0);
        applyStimulus(8'd15, 8'd1, 0);
        applyStimulus(8'd16, 8'd1, 0);
        applyStimulus(8'd50, 8'd1, 0);
        applyStimulus(8'd7, 8'd0, 0);
        applyStimulus(8'd60, 8'd6, 0);
        applyStimulus(8'd10, 8'd1, 10);

        writeNode(1, 1'b0, 3, 10, 20, 30, 'hA1, 'hA2, 'hA3, 1, 3, 4, 5);
        applyStimulus(8'd5, 8'd1, 0);
        writeNode(1, 1'b0, 3, 10, 20, 30, 'hA1, 'hA2, 'hA3, 2, 3, 4, 5);

        // Abort while the engine sits in COMPARE.
        @(negedge clock);
        req_valid = 1'b1; req_key = 8'd30; req_root = 8'd1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1 checkOutput("abort", {30'd0, rsp_valid, req_ready}, 32'd1);
        @(negedge clock) reset_n = 1'b1;
        applyStimulus(8'd30, 8'd1, 0);

        for (int n = 16; n < 32; n++) begin
            k0 = $urandom_range(0, 60);
            k1 = k0 + $urandom_range(1, 60);
            k2 = k1 + $urandom_range(1, 60);
            writeNode(n, $urandom_range(0, 3) == 0, $urandom_range(0, 3), k0, k1, k2,
                      $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                      ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(16, 31),
                      ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(16, 31),
                      ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(16, 31),
                      ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(16, 31));
        end
        for (int t = 0; t < 40; t++) begin
            a  = $urandom_range(16, 31);
            rr = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(16, 31));
            rk = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                             : mKeys[a][$urandom_range(0, NK - 1)];
            applyStimulus(rk, rr, ($urandom_range(0, 4) == 0) ? 2 : 0);
            if (t % 8 == 7)
                writeNode(a, 1'b1, 1, rk, 0, 0, $urandom_range(0, 255), 0, 0, 0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/btree_search.md
Name: btree_search

Overview:
- Sequential, parametrised B-tree lookup engine that generalises the single-node combinational key index.
- Holds the tree in an internal node RAM, loaded through a write port.
- Accepts one search request at a time and walks from a supplied root address down through child links. Each level is one node read plus one compare.
- Returns found/missing/depth-error status plus data. Sits between the key/data store loader and any client issuing key lookups.

Parameters:
KEY_BITS, 8, width of keys
DATA_BITS, 8, width of data words
ADDR_BITS, 8, node address width; address 0 is the null link
KEYS, 3, maximum keys per node (children = KEYS+1)
MAX_DEPTH, 8, maximum node visits per search before abort

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
wr_en  in  1  write node word this cycle
wr_addr  in  ADDR_BITS  node address to write
wr_node  in  NODE_BITS  packed node: leaf, count, keys[KEYS], data[KEYS], next[KEYS+1]
req_valid  in  1  search request valid
req_ready  out  1  engine idle, request accepted when valid&ready
req_key  in  KEY_BITS  key to find
req_root  in  ADDR_BITS  root node address
rsp_valid  out  1  result valid
rsp_ready  in  1  client accepts result
rsp_status  out  2  0 FOUND, 1 MISSING, 2 DEPTH_ERR
rsp_data  out  DATA_BITS  data when FOUND, else 0
rsp_node  out  ADDR_BITS  address of last node visited

Behaviour:
- Reset: FSM to IDLE. req_ready=1; rsp_valid=0; rsp_status=0; rsp_data=0; rsp_node=0; depth counter 0. RAM contents are not reset.
- FSM states are IDLE, READ, COMPARE and RESP.
- IDLE: req_ready=1. On req_valid, latch key, set cur=req_root and depth=0, go to READ.
- req_root=0 is immediately MISSING with rsp_node=0; go to RESP.
- READ: drive RAM address cur. Synchronous read, one cycle latency. Go to COMPARE.
- COMPARE, per valid slot i < min(count, KEYS):
  - eq[i] = key==keys[i]
  - gt[i] = key>keys[i], unsigned
  - Slots at or above count are ignored (eq=0, gt=0).
- COMPARE outcomes:
  - Any eq: FOUND, data from the lowest matching i.
  - Otherwise child index c = number of set gt. Keys are sorted ascending, so c = index of the first clear gt.
  - If leaf, or next[c]==0: MISSING.
  - Else if depth+1==MAX_DEPTH: DEPTH_ERR.
  - Else cur=next[c], depth++, go to READ.
  - Every terminal outcome loads the rsp_* registers and goes to RESP.
- RESP: rsp_valid=1, outputs held stable until rsp_ready. Return to IDLE on the rsp_valid&rsp_ready edge. req_ready stays 0 until IDLE.
- Latency: request accepted at edge E0, result terminating at depth d (1-based) → rsp_valid high after edge E(2d).
- Write port:
  - Accepted any cycle, in any state.
  - Same-cycle write and read of one address is read-first: the search sees old contents.
  - A node written mid-search affects only later visits.
- count>KEYS is treated as KEYS. Unsorted keys give undefined child choice but never hang; the depth bound guarantees termination.
- reset_n asserted mid-search aborts immediately with no response; RAM is preserved.

Optional Feature:
- Macro BTREE_SEARCH_STEPS_EN.
- Defined: adds output rsp_steps (clog2(MAX_DEPTH+1) bits) = number of nodes read for this result, 0 for a null root. It is registered with the other rsp_* outputs and reset to 0.
- Undefined: the port and counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Package btree_pkg holds:
  - status enum (FOUND, MISSING, DEPTH_ERR)
  - FSM state enum
  - NODE_BITS and field-offset functions parametrised by KEY_BITS/DATA_BITS/ADDR_BITS/KEYS
  - count width = clog2(KEYS+1)
- One sub-module: btree_node_compare. It is combinational: packed node plus key in; eq vector, gt vector, child index, matched data, leaf/count decode out. It is reused by the future insert engine.

Test Plan:
- Root addr 1 = {keys 10,20,30; data 0xA1,0xA2,0xA3; next 2,3,4,5}; search 20 → FOUND, data 0xA2, node 1, rsp_valid after edge E2.
- Node 3 = leaf {12,15; data 0xC1,0xC2}; search 15 from root 1 → FOUND 0xC2, node 3, after E4; search 16 → MISSING, data 0, node 3.
- Node 1 next0 rewritten to 1 (self loop), MAX_DEPTH=4, search 5 → DEPTH_ERR after E8, node 1; with BTREE_SEARCH_STEPS_EN, steps=4.
- Hold rsp_ready=0 for 10 cycles after result → rsp_* stable, req_ready=0; new req_valid ignored until handshake completes.
- Node with count=1 and stale keys in slots 1..2, search a stale key → MISSING via next[1]. Also req_root=0 → MISSING after E1.
- Assert reset_n during COMPARE → rsp_valid=0, req_ready=1 immediately. Subsequent search 30 → FOUND 0xA3 (RAM preserved).
